// File: rtl/e_tdmrc_dec_if.sv
// Bus bundle for the e_tdmrc_dec frame decryptor: keys, cipher byte handshake and result.
// Define E_TDMRC_DEC_OVF_EN to add the sticky ovf_err status signal.
interface e_tdmrc_dec_if;
  logic [31:0] master_key;
  logic [15:0] subkey;
  logic [15:0] subkey1;
  logic [15:0] subkey2;
  logic [15:0] subkey3;
  logic [7:0]  cipher_in;
  logic        cipher_valid;
  logic        cipher_ready;
  logic [39:0] plain_flat;
  logic        done;
`ifdef E_TDMRC_DEC_OVF_EN
  logic        ovf_err;

  modport master (
    output master_key, subkey, subkey1, subkey2, subkey3, cipher_in, cipher_valid,
    input  cipher_ready, plain_flat, done, ovf_err
  );

  modport slave (
    input  master_key, subkey, subkey1, subkey2, subkey3, cipher_in, cipher_valid,
    output cipher_ready, plain_flat, done, ovf_err
  );
`else
  modport master (
    output master_key, subkey, subkey1, subkey2, subkey3, cipher_in, cipher_valid,
    input  cipher_ready, plain_flat, done
  );

  modport slave (
    input  master_key, subkey, subkey1, subkey2, subkey3, cipher_in, cipher_valid,
    output cipher_ready, plain_flat, done
  );
`endif
endinterface

// File: rtl/e_tdmrc_dec.sv
// 5-byte frame decryptor: XORs each byte with one of four quadratic generators.
// Define E_TDMRC_DEC_OVF_EN to add the sticky ovf_err flag for bytes offered while busy.
module e_tdmrc_dec (
  input logic          clk,
  input logic          rst,
  e_tdmrc_dec_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StDecrypt, StFinal} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q [5];
  logic [7:0]  c_q [4];
  logic [15:0] x_q [4];
  logic [39:0] plain_q;
  logic        done_q;

  logic        ready;
  logic        accept;
  logic [15:0] key [4];
  logic [16:0] rn;
  logic [31:0] ma;
  logic [7:0]  c_new [4];
  logic [1:0]  sel;
  logic [15:0] a_sel, b_sel, x_sel, sq, t, x_new;

  assign key[0] = bus.subkey;
  assign key[1] = bus.subkey1;
  assign key[2] = bus.subkey2;
  assign key[3] = bus.subkey3;

  assign rn = {1'b0, bus.subkey} + {1'b0, bus.subkey1};
  assign ma = bus.master_key ^ {15'd0, rn};

  for (genvar k = 0; k < 4; k++) begin : g_const
    assign c_new[k] = 8'(ma * {16'd0, key[k]});
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (bus.cipher_valid) begin
          state_d = StLoad;
          idx_d   = 3'd1;
        end
      end
      StLoad: begin
        ready = 1'b1;
        if (bus.cipher_valid) begin
          if (idx_q == 3'd4) begin
            state_d = StDecrypt;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StDecrypt: begin
        if (idx_q == 3'd4) begin
          state_d = StFinal;
          idx_d   = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      StFinal: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign accept           = bus.cipher_valid & ready;
  assign bus.cipher_ready = ready;
  assign bus.plain_flat   = plain_q;
  assign bus.done         = done_q;

  // Byte order 0..4 walks generators x2, x1, x0, x3, x2.
  always_comb begin
    unique case (idx_q)
      3'd1:    sel = 2'd1;
      3'd2:    sel = 2'd0;
      3'd3:    sel = 2'd3;
      default: sel = 2'd2;
    endcase
  end

  // Generator k uses A = key[k], B = key[k+1 mod 4].
  assign a_sel = key[sel];
  assign b_sel = key[sel + 2'd1];
  assign x_sel = x_q[sel];
  assign sq    = x_sel * x_sel;
  assign t     = a_sel * sq + b_sel * x_sel + {8'd0, c_q[sel]};
  assign x_new = (t == 16'hFFFF) ? 16'd0 : t;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) data_q[i] <= 8'd0;
      for (int k = 0; k < 4; k++) c_q[k] <= 8'd0;
      x_q[0]  <= 16'd1;
      x_q[1]  <= 16'd3;
      x_q[2]  <= 16'd5;
      x_q[3]  <= 16'd7;
      plain_q <= 40'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        data_q[idx_q] <= bus.cipher_in;
        if (state_q == StIdle) begin
          for (int k = 0; k < 4; k++) c_q[k] <= c_new[k];
        end
      end
      if (state_q == StDecrypt) begin
        x_q[sel]      <= x_new;
        data_q[idx_q] <= data_q[idx_q] ^ {1'b0, x_new[6:0]};
      end
      if (state_q == StFinal) begin
        plain_q <= {data_q[0], data_q[1], data_q[2], data_q[3], data_q[4]};
        done_q  <= 1'b1;
      end
    end
  end

`ifdef E_TDMRC_DEC_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.cipher_valid && !ready) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf_err = ovf_q;
`endif

endmodule

// File: tb/tb_e_tdmrc_dec.sv
// Randomized bench for e_tdmrc_dec with a frame-level reference model and directed key cases.
`timescale 1ns/1ps
module tb_e_tdmrc_dec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  e_tdmrc_dec_if bus();

  e_tdmrc_dec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_x [4];
  logic [7:0]  m_c [4];
  logic [7:0]  m_cb [5];
  int          m_cnt  = 0;
  int          m_busy = 0;
  logic [39:0] m_plain = '0;
  logic [39:0] m_pend  = '0;
  logic        m_done  = 1'b0;
  logic        m_ovf   = 1'b0;
  logic        m_live  = 1'b0;
  logic        m_acc;

  function automatic logic [31:0] key_of(input int k);
    case (k)
      0:       return {16'd0, bus.subkey};
      1:       return {16'd0, bus.subkey1};
      2:       return {16'd0, bus.subkey2};
      default: return {16'd0, bus.subkey3};
    endcase
  endfunction

  task automatic model_latch();
    logic [31:0] ma;
    ma = bus.master_key ^ ({16'd0, bus.subkey} + {16'd0, bus.subkey1});
    for (int k = 0; k < 4; k++) m_c[k] = 8'((ma * key_of(k)) & 32'hFF);
  endtask

  task automatic model_frame();
    int          order [5] = '{2, 1, 0, 3, 2};
    logic [7:0]  p [5];
    for (int i = 0; i < 5; i++) begin
      int          g;
      logic [31:0] a, b, x, sq, t;
      g  = order[i];
      a  = key_of(g);
      b  = key_of((g + 1) % 4);
      x  = {16'd0, m_x[g]};
      sq = (x * x) & 32'hFFFF;
      t  = (a * sq + b * x + {24'd0, m_c[g]}) & 32'hFFFF;
      m_x[g] = (t == 32'd65535) ? 16'd0 : t[15:0];
      p[i] = m_cb[i] ^ {1'b0, m_x[g][6:0]};
    end
    m_pend = {p[0], p[1], p[2], p[3], p[4]};
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_x     = '{16'd1, 16'd3, 16'd5, 16'd7};
      m_c     = '{8'd0, 8'd0, 8'd0, 8'd0};
      m_cnt   = 0;
      m_busy  = 0;
      m_plain = '0;
      m_done  = 1'b0;
      m_ovf   = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      m_acc  = bus.cipher_valid && (m_busy == 0);
      if (bus.cipher_valid && m_busy != 0) m_ovf = 1'b1;
      m_done = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_plain = m_pend;
          m_done  = 1'b1;
        end
      end
      if (m_acc) begin
        if (m_cnt == 0) model_latch();
        m_cb[m_cnt] = bus.cipher_in;
        m_cnt++;
        if (m_cnt == 5) begin
          model_frame();
          m_busy = 6;
          m_cnt  = 0;
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("cipher_ready", {63'd0, bus.cipher_ready}, {63'd0, (m_busy == 0)});
      check("done", {63'd0, bus.done}, {63'd0, m_done});
      check("plain_flat", {24'd0, bus.plain_flat}, {24'd0, m_plain});
`ifdef E_TDMRC_DEC_OVF_EN
      check("ovf_err", {63'd0, bus.ovf_err}, {63'd0, m_ovf});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_keys(input logic [31:0] mk, input logic [15:0] s0, input logic [15:0] s1,
                          input logic [15:0] s2, input logic [15:0] s3);
    bus.master_key = mk;
    bus.subkey     = s0;
    bus.subkey1    = s1;
    bus.subkey2    = s2;
    bus.subkey3    = s3;
  endtask

  task automatic do_reset();
    bus.cipher_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Feeds nbytes of fr; for a full frame waits for done and returns the latency in cycles.
  task automatic send_frame(input logic [39:0] fr, input int gap, input bit flood,
                            input int nbytes, output int lat);
    lat = -1;
    for (int i = 0; i < nbytes; i++) begin
      bus.cipher_in    = fr[39 - 8 * i -: 8];
      bus.cipher_valid = 1'b1;
      tick();
      bus.cipher_valid = 1'b0;
      if (i < 4) for (int g = 0; g < gap; g++) tick();
    end
    if (nbytes == 5) begin
      bus.cipher_valid = flood;
      for (int c = 1; c <= 20; c++) begin
        bus.cipher_in = 8'($urandom);
        tick();
        if (bus.done === 1'b1) begin
          lat = c;
          break;
        end
      end
      bus.cipher_valid = 1'b0;
    end
  endtask

  task automatic frame_expect(input string name, input logic [39:0] fr, input int gap,
                              input bit flood, input logic [39:0] exp);
    int lat;
    send_frame(fr, gap, flood, 5, lat);
    check({name, "_latency"}, 64'(lat), 64'd6);
    check({name, "_plain"}, {24'd0, bus.plain_flat}, {24'd0, exp});
    check({name, "_model_pin"}, {24'd0, m_plain}, {24'd0, exp});
  endtask

  initial begin
    int lat;
    set_keys(32'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    bus.cipher_in    = 8'd0;
    bus.cipher_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_ready", {63'd0, bus.cipher_ready}, 64'd1);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_plain", {24'd0, bus.plain_flat}, 64'd0);

    frame_expect("zero_keys", 40'h1122334455, 0, 1'b0, 40'h1122334455);

    set_keys(32'd0, 16'd0, 16'd1, 16'd0, 16'd0);
    do_reset();
    frame_expect("frame1", 40'd0, 0, 1'b0, 40'h000A010000);
    frame_expect("frame2", 40'd0, 0, 1'b0, 40'h0065010000);
    do_reset();
    frame_expect("frame3", 40'd0, 0, 1'b0, 40'h000A010000);

    do_reset();
    send_frame(40'd0, 0, 1'b0, 3, lat);
    do_reset();
    frame_expect("after_abort", 40'd0, 0, 1'b0, 40'h000A010000);

    do_reset();
    frame_expect("flooded", 40'd0, 0, 1'b1, 40'h000A010000);
`ifdef E_TDMRC_DEC_OVF_EN
    for (int i = 0; i < 3; i++) tick();
    check("ovf_sticky", {63'd0, bus.ovf_err}, 64'd1);
    do_reset();
    check("ovf_cleared", {63'd0, bus.ovf_err}, 64'd0);
`endif

    do_reset();
    frame_expect("gapped", 40'd0, 2, 1'b0, 40'h000A010000);

    // Randomized frames; keys only change between frames.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_keys($urandom, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      end
      if ($urandom_range(0, 9) == 0) begin
        send_frame({$urandom, 8'($urandom)}, $urandom_range(0, 2), 1'b0,
                   $urandom_range(1, 4), lat);
        do_reset();
      end else begin
        send_frame({$urandom, 8'($urandom)}, $urandom_range(0, 2), 1'($urandom),
                   5, lat);
        check("rand_latency", 64'(lat), 64'd6);
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      end
    end

    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/e_tdmrc_dec.md
E_TDMRC_DEC -- requirements
Module: e_tdmrc_dec

Interface
REQ-001 SHALL provide clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL provide rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL provide master_key, input, 32 bits: master key.
REQ-004 SHALL provide subkey, subkey1, subkey2, subkey3, inputs, 16 bits each: generator coefficients.
REQ-005 SHALL provide cipher_in, input, 8 bits: ciphertext byte.
REQ-006 SHALL provide cipher_valid, input, 1 bit: cipher_in is valid this cycle.
REQ-007 SHALL provide cipher_ready, output, 1 bit: block accepts a byte this cycle.
REQ-008 SHALL provide plain_flat, output, 40 bits: recovered frame, byte 0 in [39:32], byte 4 in [7:0].
REQ-009 SHALL provide done, output, 1 bit: one-cycle pulse when plain_flat updates.

Function
REQ-010 SHALL process fixed 5-byte frames with states IDLE, LOAD, DECRYPT, FINAL.
REQ-011 SHALL drive cipher_ready high in IDLE and LOAD only; a byte is accepted when cipher_valid and cipher_ready are both high.
REQ-012 IDLE: on accept, SHALL store byte 0, latch key constants (REQ-016) and go to LOAD.
REQ-013 LOAD: SHALL store accepted bytes 1..4 in order; after byte 4 is accepted, SHALL go to DECRYPT on the next cycle. Gaps in cipher_valid are allowed.
REQ-014 DECRYPT: SHALL process one byte per cycle, index 0..4, for 5 cycles, then go to FINAL.
REQ-015 FINAL: SHALL load plain_flat, pulse done for 1 cycle and return to IDLE. Latency from 5th accept to done high is 6 cycles.
REQ-016 Constants: Rn = subkey + subkey1, 17-bit zero-extended to 32. ma = master_key XOR Rn. c0..c3 = (ma * subkey_k) mod 256, where k is subkey, subkey1, subkey2, subkey3. All constants are latched at byte-0 accept.
REQ-017 Generators: x0, x1, x2, x3, 16 bits each, hold state across frames.
REQ-018 Generator update: t = (A*(x*x mod 2^16) + B*x + c) mod 2^16; x_next = t mod 65535, so t=65535 gives 0.
REQ-019 Generator coefficients (A, B, c): x0 uses (subkey, subkey1, c0), x1 uses (subkey1, subkey2, c1), x2 uses (subkey2, subkey3, c2), x3 uses (subkey3, subkey, c3).
REQ-020 Byte index i SHALL select a generator by i mod 4: 0 selects x2, 1 selects x1, 2 selects x0, 3 selects x3. Byte 4 selects x2 again. Only the selected generator advances.
REQ-021 Plain byte i SHALL equal cipher byte i XOR {1'b0, x_next[6:0]}.
REQ-022 SHALL ignore cipher_valid while cipher_ready is low; no byte is stored.
REQ-023 plain_flat SHALL hold its value until the next FINAL.

Reset
REQ-024 Reset SHALL force state IDLE, index 0, plain_flat 0, done 0, cipher_ready 1 on the following cycle.
REQ-025 Reset SHALL set x0=1, x1=3, x2=5, x3=7, and clear the byte buffer and constants.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; no done pulse.

Configuration
REQ-027 With macro E_TDMRC_DEC_OVF_EN defined, SHALL add output ovf_err, 1 bit, sticky: set when cipher_valid is high while cipher_ready is low, cleared only by rst.
REQ-028 With E_TDMRC_DEC_OVF_EN undefined, ovf_err port and logic SHALL be absent; dropped bytes are silent.

Verification
REQ-029 All keys 0, frame 11 22 33 44 55 -> done after 6 cycles, plain_flat=0x1122334455.
REQ-030 master_key=0, subkey=0, subkey1=1, subkey2=0, subkey3=0, cipher 00x5 -> plain_flat=0x000A010000.
REQ-031 Same keys, second frame 00x5 without reset -> plain_flat=0x0065010000; after rst, third frame -> 0x000A010000.
REQ-032 Same keys, rst pulsed after 3 bytes, then full frame 00x5 -> no done for the aborted frame, plain_flat=0x000A010000.
REQ-033 cipher_valid held high during DECRYPT/FINAL -> those bytes are not stored; with E_TDMRC_DEC_OVF_EN, ovf_err=1 until rst.
REQ-034 Bytes fed with 2-cycle gaps -> result identical to back-to-back input.
